// File: rtl/stack_game_ctrl.sv
// stack_game_ctrl: top-level sequencer for the stacking game.
// It turns start/pause/drop button presses into spawn, slide, fall and
// clear commands for the stack datapath. It also tracks score and level and
// selects the fall speed.
// Optional feature: define STACK_GAME_HISCORE_EN to keep a high score that
// survives restarts.
module stack_game_ctrl #(
  parameter int MAX_LEVEL = 15,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               drop,
  input  logic               fall_tick,
  input  logic               land,
  input  logic [9:0]         overlap_w,
  output logic               move_en,
  output logic               fall_step,
  output logic               spawn,
  output logic               clear_stack,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic [1:0]         speed_sel,
  output logic [2:0]         state,
  output logic               game_over,
  output logic               win,
  output logic [SCORE_W-1:0] high_score
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SPAWN  = 3'd1;
  localparam logic [2:0] ST_MOVE   = 3'd2;
  localparam logic [2:0] ST_FALL   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;
  localparam logic [2:0] ST_OVER   = 3'd6;

  localparam logic [3:0] MaxLevel = 4'(MAX_LEVEL);

  logic [2:0]         state_q, state_d;
  logic [2:0]         resume_q, resume_d;
  logic               overlapZero_q, overlapZero_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         level_q, level_d;
  logic               win_q, win_d;
  logic               spawn_q, clear_q, clear_d;
  logic [1:0]         speed_q;
  logic               startPrev_q, pausePrev_q, dropPrev_q;

  logic               startPress, pausePress, dropPress;
  logic [SCORE_W-1:0] scoreInc;
  logic [3:0]         levelInc;

  assign startPress = start & ~startPrev_q;
  assign pausePress = pause & ~pausePrev_q;
  assign dropPress  = drop & ~dropPrev_q;

  assign scoreInc = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;
  assign levelInc = level_q + 4'd1;

  // Next-state and game-bookkeeping decisions for the sequencer
  always_comb begin
    state_d       = state_q;
    resume_d      = resume_q;
    overlapZero_d = overlapZero_q;
    score_d       = score_q;
    level_d       = level_q;
    win_d         = win_q;
    clear_d       = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (startPress) begin
          clear_d = 1'b1;
          score_d = '0;
          level_d = '0;
          win_d   = 1'b0;
          state_d = ST_SPAWN;
        end
      end
      ST_SPAWN: state_d = ST_MOVE;
      ST_MOVE: begin
        if (pausePress) begin
          state_d  = ST_PAUSED;
          resume_d = ST_MOVE;
        end else if (dropPress) begin
          state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (land) begin
          overlapZero_d = (overlap_w == 10'd0);
          state_d       = ST_CHECK;
        end else if (pausePress) begin
          state_d  = ST_PAUSED;
          resume_d = ST_FALL;
        end
      end
      ST_CHECK: begin
        if (overlapZero_q) begin
          win_d   = 1'b0;
          state_d = ST_OVER;
        end else begin
          score_d = scoreInc;
          level_d = levelInc;
          if (levelInc == MaxLevel) begin
            win_d   = 1'b1;
            state_d = ST_OVER;
          end else begin
            state_d = ST_SPAWN;
          end
        end
      end
      ST_PAUSED: begin
        if (pausePress) state_d = resume_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, game registers and one-cycle strobes. The edge-detect history
  // resets to "held" so a button already down at reset release must be
  // released before it counts as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      resume_q      <= ST_MOVE;
      overlapZero_q <= 1'b0;
      score_q       <= '0;
      level_q       <= '0;
      win_q         <= 1'b0;
      spawn_q       <= 1'b0;
      clear_q       <= 1'b0;
      speed_q       <= 2'd0;
      startPrev_q   <= 1'b1;
      pausePrev_q   <= 1'b1;
      dropPrev_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      resume_q      <= resume_d;
      overlapZero_q <= overlapZero_d;
      score_q       <= score_d;
      level_q       <= level_d;
      win_q         <= win_d;
      spawn_q       <= (state_q == ST_SPAWN);
      clear_q       <= clear_d;
      speed_q       <= level_q[3:2];
      startPrev_q   <= start;
      pausePrev_q   <= pause;
      dropPrev_q    <= drop;
    end
  end

`ifdef STACK_GAME_HISCORE_EN
  logic [SCORE_W-1:0] highScore_q;

  // Best score seen since power-up, taken as the game enters OVER
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      highScore_q <= '0;
    end else if ((state_d == ST_OVER) && (state_q != ST_OVER) &&
                 (score_d > highScore_q)) begin
      highScore_q <= score_d;
    end
  end

  assign high_score = highScore_q;
`else
  assign high_score = '0;
`endif

  assign state       = state_q;
  assign score       = score_q;
  assign level       = level_q;
  assign win         = win_q;
  assign speed_sel   = speed_q;
  assign spawn       = spawn_q;
  assign clear_stack = clear_q;
  assign move_en     = (state_q == ST_MOVE);
  assign game_over   = (state_q == ST_OVER);
  assign fall_step   = (state_q == ST_FALL) & fall_tick;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Self-checking bench for stack_game_ctrl. A game-level model counts
// successful landings and derives the expected score, level, win and
// high score from that count.
module tb_stack_game_ctrl;

  localparam int ML   = 9;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, pause = 1'b0, drop = 1'b0;
  logic          fall_tick = 1'b0, land = 1'b0;
  logic [9:0]    overlap_w = 10'd0;
  logic          move_en, fall_step, spawn, clear_stack, game_over, win;
  logic [SW-1:0] score, high_score;
  logic [3:0]    level;
  logic [1:0]    speed_sel;
  logic [2:0]    state;

  int testsRun  = 0;
  int failCount = 0;
  int good      = 0;
  int expHigh   = 0;
  bit expOver   = 0;
  bit expWin    = 0;

  stack_game_ctrl #(.MAX_LEVEL(ML), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .drop(drop),
    .fall_tick(fall_tick), .land(land), .overlap_w(overlap_w),
    .move_en(move_en), .fall_step(fall_step), .spawn(spawn),
    .clear_stack(clear_stack), .score(score), .level(level),
    .speed_sel(speed_sel), .state(state), .game_over(game_over),
    .win(win), .high_score(high_score)
  );

  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task applyStimulus(input logic s, input logic p, input logic d, input logic t,
                     input logic l, input logic [9:0] ow);
    @(negedge clk);
    start = s; pause = p; drop = d; fall_tick = t; land = l; overlap_w = ow;
    #1;
  endtask

  task idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  function int expScore();
    return (good > SMAX) ? SMAX : good;
  endfunction

  task checkGame(input string tag);
    checkOutput({tag, ".score"}, 32'(score), expScore());
    checkOutput({tag, ".level"}, 32'(level), good);
    checkOutput({tag, ".win"}, 32'(win), 32'(expWin));
    checkOutput({tag, ".over"}, 32'(game_over), 32'(expOver));
    checkOutput({tag, ".high"}, 32'(high_score), expHigh);
  endtask

  task startGame();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    idle();
    good = 0; expOver = 0; expWin = 0;
    checkOutput("clearPulse", 32'(clear_stack), 1);
    checkOutput("stateSpawn", 32'(state), 1);
    checkOutput("spawnNotYet", 32'(spawn), 0);
    checkOutput("scoreCleared", 32'(score), 0);
    idle();
    checkOutput("spawnPulse", 32'(spawn), 1);
    checkOutput("clearOneCycle", 32'(clear_stack), 0);
    checkOutput("stateMove", 32'(state), 2);
    checkOutput("moveEn", 32'(move_en), 1);
    idle();
    checkOutput("spawnOneCycle", 32'(spawn), 0);
    checkOutput("speedCleared", 32'(speed_sel), 0);
    checkGame("afterStart");
  endtask

  // Pause, try every input that must be ignored, then resume
  task pauseResume(input int resumeState);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    idle();
    checkOutput("paused", 32'(state), 5);
    checkOutput("pausedMoveEn", 32'(move_en), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    checkOutput("pausedFallStep", 32'(fall_step), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd7);
    idle();
    checkOutput("pausedIgnores", 32'(state), 5);
    checkOutput("pausedSpawn", 32'(spawn), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    idle();
    checkOutput("resumed", 32'(state), resumeState);
  endtask

  task dropBlock(input int ticks, input bit pauseInFall);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    idle();
    checkOutput("stateFall", 32'(state), 3);
    checkOutput("fallMoveEn", 32'(move_en), 0);
    for (int i = 0; i < ticks; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      checkOutput("fallStepOn", 32'(fall_step), 1);
      idle();
      checkOutput("fallStepOff", 32'(fall_step), 0);
    end
    if (pauseInFall) pauseResume(3);
  endtask

  task landBlock(input logic [9:0] ow, input bit withPause);
    applyStimulus(1'b0, withPause, 1'b0, 1'b0, 1'b1, ow);
    idle();
    checkOutput("stateCheck", 32'(state), 4);
    if (ow == 10'd0) begin
      expOver = 1; expWin = 0;
    end else begin
      good++;
      if (good == ML) begin
        expOver = 1; expWin = 1;
      end
    end
`ifdef STACK_GAME_HISCORE_EN
    if (expOver && expScore() > expHigh) expHigh = expScore();
`endif
    idle();
    checkOutput("afterCheck", 32'(state), expOver ? 6 : 1);
    checkGame("landed");
    idle();
    if (expOver) begin
      checkOutput("overHolds", 32'(state), 6);
    end else begin
      checkOutput("respawnMove", 32'(state), 2);
      checkOutput("respawnPulse", 32'(spawn), 1);
      idle();
    end
    checkOutput("speedSel", 32'(speed_sel), good / 4);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    checkOutput("rstState", 32'(state), 0);
    checkOutput("rstScore", 32'(score), 0);
    checkOutput("rstLevel", 32'(level), 0);
    checkOutput("rstOver", 32'(game_over), 0);
    checkOutput("rstHigh", 32'(high_score), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle();
    idle();
    checkOutput("idleState", 32'(state), 0);
    checkOutput("idleStrobes", 32'({move_en, spawn, clear_stack, fall_step}), 0);

    // start held across reset must not launch a game
    @(negedge clk);
    start = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("heldStartNoFire", 32'(state), 0);
    checkOutput("heldStartNoClear", 32'(clear_stack), 0);
    idle();

    // Directed game: 3 ticks then a good landing at width 40
    startGame();
    dropBlock(3, 1'b0);
    landBlock(10'd40, 1'b0);

    // start in MOVE is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    idle();
    checkOutput("startIgnoredMove", 32'(state), 2);
    checkGame("startIgnored");

    // pause and drop together in MOVE: pause wins, drop is lost
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
    idle();
    checkOutput("pauseBeatsDrop", 32'(state), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    checkOutput("tickWhilePaused", 32'(fall_step), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    idle();
    checkOutput("dropWasLost", 32'(state), 2);

    // pause inside FALL, then land together with pause: land wins
    dropBlock(1, 1'b1);
    landBlock(10'd3, 1'b1);

    // zero overlap ends the game without a win
    dropBlock(2, 1'b0);
    landBlock(10'd0, 1'b0);
    checkOutput("lossScore", 32'(score), 2);

    // Randomised games; even games never miss so they run to a win
    for (int g = 0; g < 6; g++) begin
      startGame();
      while (!expOver) begin
        logic [9:0] ow;
        if ($urandom_range(0, 3) == 0) pauseResume(2);
        dropBlock($urandom_range(0, 3), $urandom_range(0, 3) == 0);
        if ((g % 2) == 1 && $urandom_range(0, 5) == 0) ow = 10'd0;
        else ow = 10'($urandom_range(1, 1023));
        landBlock(ow, $urandom_range(0, 2) == 0);
      end
    end

    // Asynchronous reset mid-game
    startGame();
    dropBlock(1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    good = 0; expOver = 0; expWin = 0; expHigh = 0;
    checkOutput("asyncRstState", 32'(state), 0);
    checkGame("asyncRst");
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
